// File: rtl/axi4lite_req_arbiter.sv
// Shares one AXI4-lite master between N pulse-request/pulse-ack requesters, with separate round-robin arbiters for the write and read paths.
// Latency: a request pulse in cycle t raises valid at t+2; bvalid/rvalid in cycle b gives the ack at b+1; the next grant's valid comes at b+2.
// Backpressure: one outstanding transaction per path; pulses from requesters already pending or in flight are ignored.
module axi4lite_req_arbiter #(
  parameter int N  = 2,
  parameter int AW = 8
) (
  input  logic            aclk,
  input  logic            areset,
  input  logic [N-1:0]    req_wr,
  input  logic [N*AW-1:0] req_wr_adr,
  input  logic [N*32-1:0] req_wr_dat,
  input  logic [N*4-1:0]  req_wr_sel,
  output logic [N-1:0]    req_wr_ack,
  input  logic [N-1:0]    req_rd,
  input  logic [N*AW-1:0] req_rd_adr,
  output logic [N-1:0]    req_rd_ack,
  output logic [31:0]     req_rd_dat,
  output logic            m_awvalid,
  input  logic            m_awready,
  output logic [AW-1:0]   m_awaddr,
  output logic [2:0]      m_awprot,
  output logic            m_wvalid,
  input  logic            m_wready,
  output logic [31:0]     m_wdata,
  output logic [3:0]      m_wstrb,
  input  logic            m_bvalid,
  output logic            m_bready,
  input  logic [1:0]      m_bresp,
  output logic            m_arvalid,
  input  logic            m_arready,
  output logic [AW-1:0]   m_araddr,
  output logic [2:0]      m_arprot,
  input  logic            m_rvalid,
  output logic            m_rready,
  input  logic [31:0]     m_rdata,
  input  logic [1:0]      m_rresp
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [PW-1:0] PTR_RST = PW'(N - 1);

  typedef enum logic [1:0] {W_IDLE, W_ADDR_DATA, W_RESP} wr_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_e;

  // Error responses still complete the transfer, so the response codes are not inspected.
  logic unused_resp;
  assign unused_resp = ^{m_bresp, m_rresp};

  // First pending requester after ptr, wrapping around; the ptr itself is checked last.
  function automatic logic [PW-1:0] rr_pick(input logic [N-1:0] pend, input logic [PW-1:0] ptr);
    logic [PW-1:0] pick;
    logic [PW-1:0] idx;
    logic          found;
    pick  = ptr;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (!found && pend[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // ---------------- write path state ----------------
  wr_state_e       wr_state_q, wr_state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, wr_gnt_q, wr_gnt_d, wr_pick;
  logic [N-1:0]    pend_wr_q, pend_wr_d, wr_clr, wr_inflight, wr_ack_q, wr_ack_d;
  logic            awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic [AW-1:0]   awaddr_q, awaddr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      wstrb_q, wstrb_d;

  // ---------------- read path state ----------------
  rd_state_e       rd_state_q, rd_state_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d, rd_gnt_q, rd_gnt_d, rd_pick;
  logic [N-1:0]    pend_rd_q, pend_rd_d, rd_clr, rd_inflight, rd_ack_q, rd_ack_d;
  logic            arvalid_q, arvalid_d, rready_q, rready_d;
  logic [AW-1:0]   araddr_q, araddr_d;
  logic [31:0]     rd_dat_q, rd_dat_d;

  assign wr_pick = rr_pick(pend_wr_q, wr_ptr_q);
  assign rd_pick = rr_pick(pend_rd_q, rd_ptr_q);

  // Write FSM next state: grant, hold AW/W valids independently, wait for B.
  always_comb begin
    wr_state_d = wr_state_q;
    wr_ptr_d   = wr_ptr_q;
    wr_gnt_d   = wr_gnt_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    bready_d   = bready_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    wr_ack_d   = '0;
    wr_clr     = '0;
    case (wr_state_q)
      W_IDLE: begin
        if (|pend_wr_q) begin
          wr_state_d      = W_ADDR_DATA;
          wr_gnt_d        = wr_pick;
          wr_ptr_d        = wr_pick;
          awaddr_d        = req_wr_adr[int'(wr_pick)*AW +: AW];
          wdata_d         = req_wr_dat[int'(wr_pick)*32 +: 32];
          wstrb_d         = req_wr_sel[int'(wr_pick)*4 +: 4];
          awvalid_d       = 1'b1;
          wvalid_d        = 1'b1;
          wr_clr[wr_pick] = 1'b1;
        end
      end
      W_ADDR_DATA: begin
        awvalid_d = awvalid_q & ~m_awready;
        wvalid_d  = wvalid_q & ~m_wready;
        if (!awvalid_d && !wvalid_d) begin
          wr_state_d = W_RESP;
          bready_d   = 1'b1;
        end
      end
      W_RESP: begin
        if (m_bvalid) begin
          wr_state_d         = W_IDLE;
          bready_d           = 1'b0;
          wr_ack_d[wr_gnt_q] = 1'b1;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  // Read FSM next state: grant, hold AR until accepted, capture R data.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_ptr_d   = rd_ptr_q;
    rd_gnt_d   = rd_gnt_q;
    arvalid_d  = arvalid_q;
    rready_d   = rready_q;
    araddr_d   = araddr_q;
    rd_dat_d   = rd_dat_q;
    rd_ack_d   = '0;
    rd_clr     = '0;
    case (rd_state_q)
      R_IDLE: begin
        if (|pend_rd_q) begin
          rd_state_d      = R_ADDR;
          rd_gnt_d        = rd_pick;
          rd_ptr_d        = rd_pick;
          araddr_d        = req_rd_adr[int'(rd_pick)*AW +: AW];
          arvalid_d       = 1'b1;
          rd_clr[rd_pick] = 1'b1;
        end
      end
      R_ADDR: begin
        if (m_arready) begin
          rd_state_d = R_DATA;
          arvalid_d  = 1'b0;
          rready_d   = 1'b1;
        end
      end
      R_DATA: begin
        if (m_rvalid) begin
          rd_state_d         = R_IDLE;
          rready_d           = 1'b0;
          rd_dat_d           = m_rdata;
          rd_ack_d[rd_gnt_q] = 1'b1;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Pending flags: new pulses latch unless already pending or in flight; a grant clears its flag.
  always_comb begin
    wr_inflight = '0;
    rd_inflight = '0;
    if (wr_state_q != W_IDLE) wr_inflight[wr_gnt_q] = 1'b1;
    if (rd_state_q != R_IDLE) rd_inflight[rd_gnt_q] = 1'b1;
    pend_wr_d = (pend_wr_q & ~wr_clr) | (req_wr & ~pend_wr_q & ~wr_inflight);
    pend_rd_d = (pend_rd_q & ~rd_clr) | (req_rd & ~pend_rd_q & ~rd_inflight);
  end

  // State registers for both paths; reset abandons any transaction without acking.
  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_state_q <= W_IDLE;
      wr_ptr_q   <= PTR_RST;
      wr_gnt_q   <= '0;
      pend_wr_q  <= '0;
      wr_ack_q   <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      rd_state_q <= R_IDLE;
      rd_ptr_q   <= PTR_RST;
      rd_gnt_q   <= '0;
      pend_rd_q  <= '0;
      rd_ack_q   <= '0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      araddr_q   <= '0;
      rd_dat_q   <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_ptr_q   <= wr_ptr_d;
      wr_gnt_q   <= wr_gnt_d;
      pend_wr_q  <= pend_wr_d;
      wr_ack_q   <= wr_ack_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      bready_q   <= bready_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      rd_state_q <= rd_state_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_gnt_q   <= rd_gnt_d;
      pend_rd_q  <= pend_rd_d;
      rd_ack_q   <= rd_ack_d;
      arvalid_q  <= arvalid_d;
      rready_q   <= rready_d;
      araddr_q   <= araddr_d;
      rd_dat_q   <= rd_dat_d;
    end
  end

  // Outputs come straight from registers; protection bits are always unprivileged/secure/data.
  always_comb begin
    m_awvalid  = awvalid_q;
    m_awaddr   = awaddr_q;
    m_awprot   = 3'b000;
    m_wvalid   = wvalid_q;
    m_wdata    = wdata_q;
    m_wstrb    = wstrb_q;
    m_bready   = bready_q;
    m_arvalid  = arvalid_q;
    m_araddr   = araddr_q;
    m_arprot   = 3'b000;
    m_rready   = rready_q;
    req_wr_ack = wr_ack_q;
    req_rd_ack = rd_ack_q;
    req_rd_dat = rd_dat_q;
  end

endmodule

// File: tb/tb_axi4lite_req_arbiter.sv
// Directed bench for axi4lite_req_arbiter (N=2, AW=8) with a configurable AXI slave.
// Inputs change and outputs are sampled on the falling clock edge.
// Slave records every handshake and ack with its cycle number for the test tasks.
module tb_axi4lite_req_arbiter;
  localparam int N  = 2;
  localparam int AW = 8;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  logic            areset = 1'b1;
  logic [N-1:0]    req_wr = '0, req_rd = '0;
  logic [N*AW-1:0] req_wr_adr = '0, req_rd_adr = '0;
  logic [N*32-1:0] req_wr_dat = '0;
  logic [N*4-1:0]  req_wr_sel = '0;
  logic [N-1:0]    req_wr_ack, req_rd_ack;
  logic [31:0]     req_rd_dat;
  logic            m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic            m_arvalid, m_arready, m_rvalid, m_rready;
  logic [AW-1:0]   m_awaddr, m_araddr;
  logic [2:0]      m_awprot, m_arprot;
  logic [31:0]     m_wdata, m_rdata;
  logic [3:0]      m_wstrb;
  logic [1:0]      m_bresp, m_rresp;

  axi4lite_req_arbiter #(.N(N), .AW(AW)) dut (
    .aclk(aclk), .areset(areset),
    .req_wr(req_wr), .req_wr_adr(req_wr_adr), .req_wr_dat(req_wr_dat),
    .req_wr_sel(req_wr_sel), .req_wr_ack(req_wr_ack),
    .req_rd(req_rd), .req_rd_adr(req_rd_adr), .req_rd_ack(req_rd_ack),
    .req_rd_dat(req_rd_dat),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awprot(m_awprot),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arprot(m_arprot),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp)
  );

  typedef struct packed {
    logic [31:0] cyc;
    logic [31:0] data;
    logic [7:0]  addr;
    logic [3:0]  strb;
    logic [2:0]  prot;
  } ev_t;

  ev_t aw_q[$], w_q[$], ar_q[$], wack_q[$], rack_q[$];

  int         aw_delay = 0, w_delay = 0, ar_delay = 0;
  int         aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
  bit         b_hold = 1'b0;
  logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [7:0] ar_last = 8'h00;

  function automatic ev_t mk(int c, logic [31:0] d, logic [7:0] a, logic [3:0] s, logic [2:0] p);
    ev_t e;
    e.cyc = c; e.data = d; e.addr = a; e.strb = s; e.prot = p;
    return e;
  endfunction

  // Slave model and event recorder; a handshake is logged in the cycle it completes.
  initial begin
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'b00;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0;   m_rresp = 2'b00;
    forever begin
      @(negedge aclk);
      if (m_awvalid) begin
        if (aw_cnt >= aw_delay) begin
          m_awready = 1'b1; aw_q.push_back(mk(cyc, 32'h0, m_awaddr, 4'h0, m_awprot));
        end else begin
          m_awready = 1'b0; aw_cnt++;
        end
      end else begin
        m_awready = 1'b0; aw_cnt = 0;
      end
      if (m_wvalid) begin
        if (w_cnt >= w_delay) begin
          m_wready = 1'b1; w_q.push_back(mk(cyc, m_wdata, 8'h0, m_wstrb, 3'b0));
        end else begin
          m_wready = 1'b0; w_cnt++;
        end
      end else begin
        m_wready = 1'b0; w_cnt = 0;
      end
      m_bvalid = m_bready && !b_hold;
      m_bresp  = bresp_cfg;
      if (m_arvalid) begin
        if (ar_cnt >= ar_delay) begin
          m_arready = 1'b1; ar_last = m_araddr;
          ar_q.push_back(mk(cyc, 32'h0, m_araddr, 4'h0, m_arprot));
        end else begin
          m_arready = 1'b0; ar_cnt++;
        end
      end else begin
        m_arready = 1'b0; ar_cnt = 0;
      end
      m_rvalid = m_rready;
      m_rdata  = 32'hC0DE_0000 | {24'h0, ar_last};
      m_rresp  = rresp_cfg;
      if (req_wr_ack != '0) wack_q.push_back(mk(cyc, 32'h0, {6'h0, req_wr_ack}, 4'h0, 3'b0));
      if (req_rd_ack != '0) rack_q.push_back(mk(cyc, req_rd_dat, {6'h0, req_rd_ack}, 4'h0, 3'b0));
    end
  end

  task automatic clear_logs();
    aw_q.delete(); w_q.delete(); ar_q.delete(); wack_q.delete(); rack_q.delete();
  endtask

  task automatic do_reset();
    @(negedge aclk);
    areset = 1'b1; req_wr = '0; req_rd = '0;
    repeat (3) @(negedge aclk);
    areset = 1'b0;
    clear_logs();
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge aclk);
    #2;
  endtask

  task automatic pulse(input logic [N-1:0] wr, input logic [N-1:0] rd, output int c);
    @(negedge aclk);
    req_wr = wr; req_rd = rd; c = cyc;
    @(negedge aclk);
    req_wr = '0; req_rd = '0;
  endtask

  task automatic test_reset();
    do_reset();
    #2;
    checks++;
    if ({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, req_wr_ack, req_rd_ack} !== '0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=0", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, req_wr_ack, req_rd_ack});
    end
    checks++;
    if ({req_rd_dat, m_awaddr, m_wdata, m_wstrb, m_araddr} !== '0) begin
      failures++;
      $display("FAIL reset_data got=%h exp=0", {req_rd_dat, m_awaddr, m_wdata, m_wstrb, m_araddr});
    end
  endtask

  task automatic test_single_write();
    int c;
    do_reset();
    req_wr_adr = {8'h00, 8'h04}; req_wr_dat = {32'h0, 32'hDEADBEEF}; req_wr_sel = {4'h0, 4'hF};
    pulse(2'b01, 2'b00, c);
    wait_cycles(10);
    checks++;
    if (aw_q.size() != 1 || wack_q.size() != 1) begin
      failures++; $display("FAIL sw_counts got=%0d/%0d exp=1/1", aw_q.size(), wack_q.size());
    end else begin
      checks++;
      if (aw_q[0].cyc !== 32'(c + 2)) begin
        failures++; $display("FAIL sw_aw_cycle got=%0d exp=%0d", aw_q[0].cyc, c + 2);
      end
      checks++;
      if (aw_q[0].addr !== 8'h04 || aw_q[0].prot !== 3'b000) begin
        failures++; $display("FAIL sw_awaddr got=%h/%b exp=04/000", aw_q[0].addr, aw_q[0].prot);
      end
      checks++;
      if (w_q.size() != 1 || w_q[0].data !== 32'hDEADBEEF || w_q[0].strb !== 4'hF) begin
        failures++; $display("FAIL sw_wdata got=%h/%h exp=deadbeef/f", w_q[0].data, w_q[0].strb);
      end
      checks++;
      if (wack_q[0].addr !== 8'h01 || wack_q[0].cyc !== 32'(c + 4)) begin
        failures++; $display("FAIL sw_ack got=%h@%0d exp=01@%0d", wack_q[0].addr, wack_q[0].cyc, c + 4);
      end
    end
  endtask

  task automatic test_dual_read();
    int c;
    do_reset();
    req_rd_adr = {8'h04, 8'h00};
    pulse(2'b00, 2'b11, c);
    wait_cycles(12);
    checks++;
    if (ar_q.size() != 2 || rack_q.size() != 2) begin
      failures++; $display("FAIL dr_counts got=%0d/%0d exp=2/2", ar_q.size(), rack_q.size());
    end else begin
      checks++;
      if (ar_q[0].addr !== 8'h00 || ar_q[1].addr !== 8'h04) begin
        failures++; $display("FAIL dr_ar_order got=%h,%h exp=00,04", ar_q[0].addr, ar_q[1].addr);
      end
      checks++;
      if (rack_q[0].addr !== 8'h01 || rack_q[0].data !== 32'hC0DE0000 || rack_q[0].cyc !== 32'(c + 4)) begin
        failures++; $display("FAIL dr_ack0 got=%h/%h@%0d exp=01/c0de0000@%0d", rack_q[0].addr, rack_q[0].data, rack_q[0].cyc, c + 4);
      end
      checks++;
      if (rack_q[1].addr !== 8'h02 || rack_q[1].data !== 32'hC0DE0004 || rack_q[1].cyc !== 32'(c + 7)) begin
        failures++; $display("FAIL dr_ack1 got=%h/%h@%0d exp=02/c0de0004@%0d", rack_q[1].addr, rack_q[1].data, rack_q[1].cyc, c + 7);
      end
    end
    checks++;
    if (req_rd_dat !== 32'hC0DE0004) begin
      failures++; $display("FAIL dr_hold got=%h exp=c0de0004", req_rd_dat);
    end
  endtask

  task automatic test_fairness();
    int c;
    bit re0, re1;
    do_reset();
    req_wr_adr = {8'h20, 8'h10}; req_wr_dat = {32'h2222_2222, 32'h1111_1111}; req_wr_sel = 8'hFF;
    re0 = 1'b0; re1 = 1'b0;
    @(negedge aclk); req_wr = 2'b11;
    for (int k = 0; k < 30; k++) begin
      @(negedge aclk);
      req_wr = '0;
      if (req_wr_ack[0] && !re0) begin req_wr[0] = 1'b1; re0 = 1'b1; end
      if (req_wr_ack[1] && !re1) begin req_wr[1] = 1'b1; re1 = 1'b1; end
    end
    req_wr = '0;
    #2;
    checks++;
    if (aw_q.size() != 4 || wack_q.size() != 4) begin
      failures++; $display("FAIL rr_counts got=%0d/%0d exp=4/4", aw_q.size(), wack_q.size());
    end else begin
      checks++;
      if ({aw_q[0].addr, aw_q[1].addr, aw_q[2].addr, aw_q[3].addr} !== 32'h10201020) begin
        failures++; $display("FAIL rr_order got=%h exp=10201020", {aw_q[0].addr, aw_q[1].addr, aw_q[2].addr, aw_q[3].addr});
      end
      checks++;
      if ({wack_q[0].addr, wack_q[1].addr, wack_q[2].addr, wack_q[3].addr} !== 32'h01020102) begin
        failures++; $display("FAIL rr_acks got=%h exp=01020102", {wack_q[0].addr, wack_q[1].addr, wack_q[2].addr, wack_q[3].addr});
      end
      checks++;
      if (aw_q[1].cyc !== wack_q[0].cyc + 1) begin
        failures++; $display("FAIL rr_b2b got=%0d exp=%0d", aw_q[1].cyc, wack_q[0].cyc + 1);
      end
    end
    // Last grant was 0: with both pending, requester 1 must win next.
    pulse(2'b01, 2'b00, c);
    wait_cycles(8);
    clear_logs();
    pulse(2'b11, 2'b00, c);
    wait_cycles(14);
    checks++;
    if (aw_q.size() != 2 || aw_q[0].addr !== 8'h20 || aw_q[1].addr !== 8'h10) begin
      failures++; $display("FAIL rr_ptr got=%0d:%h,%h exp=2:20,10", aw_q.size(), aw_q[0].addr, aw_q[1].addr);
    end
  endtask

  task automatic test_aw_before_w();
    int c;
    do_reset();
    w_delay = 3;
    req_wr_adr = {8'h00, 8'h18}; req_wr_dat = {32'h0, 32'hA5A5_5A5A}; req_wr_sel = {4'h0, 4'h6};
    pulse(2'b01, 2'b00, c);
    repeat (2) @(negedge aclk);
    #1;
    checks++;
    if (m_awvalid !== 1'b0 || m_wvalid !== 1'b1) begin
      failures++; $display("FAIL aw_first got=aw%b/w%b exp=aw0/w1", m_awvalid, m_wvalid);
    end
    wait_cycles(10);
    w_delay = 0;
    checks++;
    if (aw_q.size() != 1 || w_q.size() != 1 || aw_q[0].cyc !== 32'(c + 2) || w_q[0].cyc !== 32'(c + 5)) begin
      failures++; $display("FAIL aw_w_cycles got=%0d,%0d exp=%0d,%0d", aw_q[0].cyc, w_q[0].cyc, c + 2, c + 5);
    end
    checks++;
    if (wack_q.size() != 1 || wack_q[0].cyc !== 32'(c + 7) || wack_q[0].addr !== 8'h01) begin
      failures++; $display("FAIL aw_w_ack got=%0d:%h@%0d exp=1:01@%0d", wack_q.size(), wack_q[0].addr, wack_q[0].cyc, c + 7);
    end
  endtask

  task automatic test_concurrent();
    int c;
    do_reset();
    rresp_cfg = 2'b10;
    req_wr_adr = {8'h08, 8'h00}; req_wr_dat = {32'h1234_5678, 32'h0}; req_wr_sel = {4'h3, 4'h0};
    req_rd_adr = {8'h00, 8'h0C};
    pulse(2'b10, 2'b01, c);
    wait_cycles(10);
    rresp_cfg = 2'b00;
    checks++;
    if (wack_q.size() != 1 || wack_q[0].addr !== 8'h02 || wack_q[0].cyc !== 32'(c + 4)) begin
      failures++; $display("FAIL cc_wack got=%0d:%h@%0d exp=1:02@%0d", wack_q.size(), wack_q[0].addr, wack_q[0].cyc, c + 4);
    end
    checks++;
    if (rack_q.size() != 1 || rack_q[0].addr !== 8'h01 || rack_q[0].cyc !== 32'(c + 4)) begin
      failures++; $display("FAIL cc_rack got=%0d:%h@%0d exp=1:01@%0d", rack_q.size(), rack_q[0].addr, rack_q[0].cyc, c + 4);
    end
    checks++;
    if (rack_q.size() != 1 || rack_q[0].data !== 32'hC0DE000C) begin
      failures++; $display("FAIL cc_rdat got=%h exp=c0de000c", rack_q[0].data);
    end
    checks++;
    if (w_q.size() != 1 || w_q[0].data !== 32'h1234_5678 || w_q[0].strb !== 4'h3 || aw_q[0].addr !== 8'h08) begin
      failures++; $display("FAIL cc_wr got=%h/%h/%h exp=08/12345678/3", aw_q[0].addr, w_q[0].data, w_q[0].strb);
    end
  endtask

  task automatic test_reset_mid_resp();
    int c;
    do_reset();
    b_hold = 1'b1;
    req_wr_adr = {8'h30, 8'h2C}; req_wr_dat = {32'h3333_3333, 32'h2C2C_2C2C}; req_wr_sel = 8'hFF;
    pulse(2'b01, 2'b00, c);
    repeat (3) @(negedge aclk);
    #1;
    checks++;
    if (m_bready !== 1'b1) begin
      failures++; $display("FAIL mr_in_resp got=%b exp=1", m_bready);
    end
    areset = 1'b1;
    @(negedge aclk);
    #1;
    checks++;
    if ({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, req_wr_ack, req_rd_ack} !== '0) begin
      failures++; $display("FAIL mr_outputs got=%b exp=0", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, req_wr_ack, req_rd_ack});
    end
    @(negedge aclk);
    areset = 1'b0;
    b_hold = 1'b0;
    wait_cycles(6);
    checks++;
    if (wack_q.size() != 0) begin
      failures++; $display("FAIL mr_no_ack got=%0d exp=0", wack_q.size());
    end
    clear_logs();
    pulse(2'b10, 2'b00, c);
    wait_cycles(10);
    checks++;
    if (aw_q.size() != 1 || aw_q[0].addr !== 8'h30 || wack_q.size() != 1 || wack_q[0].addr !== 8'h02) begin
      failures++; $display("FAIL mr_next got=%0d:%h ack %0d:%h exp=1:30 ack 1:02", aw_q.size(), aw_q[0].addr, wack_q.size(), wack_q[0].addr);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_dual_read();
    test_fairness();
    test_aw_before_w();
    test_concurrent();
    test_reset_mid_resp();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
